// File: rtl/gpio_in_debounce.sv
// Pad input conditioner: per-pin synchroniser, programmable debounce and registered edge pulses.
// Optional rejected-glitch counter when GPIO_DEBOUNCE_GLITCH_CNT_EN is defined.
module gpio_in_debounce #(
    parameter int N           = 24,
    parameter int CNTW        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            cfg_en,
    input  logic [CNTW-1:0] cfg_limit,
    input  logic [N-1:0]    pad_in,
`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
    input  logic            glitch_clr,
    output logic [15:0]     glitch_cnt,
`endif
    output logic [N-1:0]    gpio_in,
    output logic [N-1:0]    edge_rise,
    output logic [N-1:0]    edge_fall
);

    logic [N-1:0]    sync_q [SYNC_STAGES];
    logic [N-1:0]    sync_d [SYNC_STAGES];
    logic [CNTW-1:0] cnt_q  [N];
    logic [CNTW-1:0] cnt_d  [N];
    logic [N-1:0]    gpio_q, gpio_d;
    logic [N-1:0]    rise_q, rise_d;
    logic [N-1:0]    fall_q, fall_d;
    logic [N-1:0]    s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = pad_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Counter holds the number of consecutive cycles s has disagreed with the accepted level.
    always_comb begin
        gpio_d = gpio_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (!cfg_en) begin
                gpio_d[i] = s[i];
            end else if (s[i] != gpio_q[i]) begin
                if (cnt_q[i] >= cfg_limit) begin
                    gpio_d[i] = s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNTW'(1);
                end
            end
        end
        rise_d = gpio_d & ~gpio_q;
        fall_d = ~gpio_d & gpio_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
            gpio_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            gpio_q <= gpio_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign gpio_in   = gpio_q;
    assign edge_rise = rise_q;
    assign edge_fall = fall_q;

`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
    logic [15:0] glitch_q, glitch_d;
    logic        glitch_evt;

    // A non-zero count that meets an agreeing sample is a pulse that was rejected.
    always_comb begin
        glitch_evt = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q[i] != '0 && s[i] == gpio_q[i]) begin
                glitch_evt = 1'b1;
            end
        end
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = '0;
        end else if (glitch_evt && glitch_q != 16'hFFFF) begin
            glitch_d = glitch_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Self-checking bench for gpio_in_debounce: directed scenarios plus randomized traffic
// compared against a history-based reference model.
module tb_gpio_in_debounce;

    localparam int N    = 24;
    localparam int CNTW = 16;
    localparam int SS   = 2;
    localparam int HD   = 512;

    logic            clk = 1'b0;
    logic            nreset;
    logic            cfg_en;
    logic [CNTW-1:0] cfg_limit;
    logic [N-1:0]    pad_in;
    logic            glitch_clr;
    logic [15:0]     glitch_cnt;
    logic [N-1:0]    gpio_in, edge_rise, edge_fall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpio_in_debounce #(.N(N), .CNTW(CNTW), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .cfg_en    (cfg_en),
        .cfg_limit (cfg_limit),
        .pad_in    (pad_in),
`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
        .glitch_clr(glitch_clr),
        .glitch_cnt(glitch_cnt),
`endif
        .gpio_in   (gpio_in),
        .edge_rise (edge_rise),
        .edge_fall (edge_fall)
    );

`ifndef GPIO_DEBOUNCE_GLITCH_CNT_EN
    assign glitch_cnt = 16'h0;
`endif

    // ---------------- reference model ----------------
    // Keeps a history of pad samples and enable; a pin accepts a new level once the
    // synchronised input has disagreed with the accepted level for more than cfg_limit
    // consecutive enabled samples since reset.
    logic [N-1:0] pad_h [HD];
    bit           en_h  [HD];
    int           cyc = 0;
    int           c0  = 0;
    logic [N-1:0] m_gpio = '0, m_rise = '0, m_fall = '0;
    logic [15:0]  m_glitch = '0;

    function automatic logic s_at(int c, int i);
        if (c - SS < c0) return 1'b0;
        return pad_h[(c - SS) % HD][i];
    endfunction

    function automatic int run_len(int from, int i, logic g);
        int n = 0;
        for (int j = from; j >= c0 && n < HD - 8; j--) begin
            if (!en_h[j % HD] || s_at(j, i) == g) break;
            n++;
        end
        return n;
    endfunction

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_gpio   = '0;
            m_rise   = '0;
            m_fall   = '0;
            m_glitch = '0;
            c0       = cyc;
        end else begin
            logic [N-1:0] ng;
            bit           ev;
            logic         sv;
            pad_h[cyc % HD] = pad_in;
            en_h[cyc % HD]  = cfg_en;
            ng = m_gpio;
            ev = 1'b0;
            for (int i = 0; i < N; i++) begin
                sv = s_at(cyc, i);
                if (sv == m_gpio[i] && run_len(cyc - 1, i, m_gpio[i]) > 0) ev = 1'b1;
                if (!cfg_en) ng[i] = sv;
                else if (sv != m_gpio[i] && run_len(cyc, i, m_gpio[i]) > int'(cfg_limit)) ng[i] = sv;
            end
            m_rise = ng & ~m_gpio;
            m_fall = ~ng & m_gpio;
            m_gpio = ng;
            if (glitch_clr) m_glitch = '0;
            else if (ev && m_glitch != 16'hFFFF) m_glitch = m_glitch + 16'd1;
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle(input logic [N-1:0] v);
        cfg_en = 1'b0;
        pad_in = v;
        repeat (5) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        nreset = 1'b0; cfg_en = 1'b0; cfg_limit = '0; pad_in = '0; glitch_clr = 1'b0;
        repeat (3) tick();
        n_checks++; if (gpio_in !== '0)   begin n_fail++; $display("FAIL reset_gpio got %h want 0", gpio_in); end
        n_checks++; if (edge_rise !== '0) begin n_fail++; $display("FAIL reset_rise got %h want 0", edge_rise); end
        n_checks++; if (edge_fall !== '0) begin n_fail++; $display("FAIL reset_fall got %h want 0", edge_fall); end
`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
        n_checks++; if (glitch_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_glitch got %h want 0", glitch_cnt); end
`endif
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        int seen = -1, pulses = 0;
        settle('0);
        pad_in[1] = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (gpio_in[1] && seen < 0) seen = t;
            pulses += int'(edge_rise[1]);
            n_checks++; if (gpio_in !== m_gpio) begin n_fail++; $display("FAIL bypass_model got %h want %h", gpio_in, m_gpio); end
        end
        n_checks++; if (seen != 3)   begin n_fail++; $display("FAIL bypass_latency got %0d want 3", seen); end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL bypass_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_debounce();
        int seen = -1, pulses = 0;
        settle('0);
        cfg_en = 1'b1; cfg_limit = 16'd10;
        pad_in[1] = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (gpio_in[1] && seen < 0) seen = t;
            pulses += int'(edge_rise[1]);
            n_checks++; if (edge_rise !== m_rise) begin n_fail++; $display("FAIL debounce_rise got %h want %h", edge_rise, m_rise); end
        end
        n_checks++; if (seen != 13)  begin n_fail++; $display("FAIL debounce_latency got %0d want 13", seen); end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL debounce_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_glitch();
        logic [15:0] g0;
        int bad = 0;
        settle('0);
        cfg_en = 1'b1; cfg_limit = 16'd10;
        tick();
        g0 = glitch_cnt;
        pad_in[5] = 1'b1;
        repeat (6) tick();
        pad_in[5] = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (gpio_in[5] || edge_rise[5] || edge_fall[5]) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL glitch_pass got %0d cycles active want 0", bad); end
`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
        n_checks++; if (glitch_cnt !== g0 + 16'd1) begin n_fail++; $display("FAIL glitch_count got %h want %h", glitch_cnt, g0 + 16'd1); end
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        n_checks++; if (glitch_cnt !== 16'h0) begin n_fail++; $display("FAIL glitch_clr got %h want 0", glitch_cnt); end
`endif
    endtask

    task automatic test_multi();
        int seen = -1, pulses = 0;
        logic [N-1:0] r = '0;
        settle('0);
        cfg_en = 1'b1; cfg_limit = 16'd4;
        pad_in = 24'hFFFFFF;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (gpio_in == 24'hFFFFFF && seen < 0) begin seen = t; r = edge_rise; end
            if (edge_rise != '0) pulses++;
        end
        n_checks++; if (seen != 7)        begin n_fail++; $display("FAIL multi_latency got %0d want 7", seen); end
        n_checks++; if (r !== 24'hFFFFFF) begin n_fail++; $display("FAIL multi_rise got %h want ffffff", r); end
        n_checks++; if (pulses != 1)      begin n_fail++; $display("FAIL multi_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_reset_mid();
        int seen = -1;
        logic [N-1:0] g = '0, r = '0;
        settle(24'h0000F0);
        cfg_en = 1'b1; cfg_limit = 16'd10;
        pad_in = 24'h0000F4;
        repeat (SS + 5) tick();
        n_checks++; if (gpio_in !== 24'h0000F0) begin n_fail++; $display("FAIL rstmid_pre got %h want 0000f0", gpio_in); end
        nreset = 1'b0;
        #1;
        n_checks++; if (gpio_in !== '0) begin n_fail++; $display("FAIL rstmid_gpio got %h want 0", gpio_in); end
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (gpio_in[2] && seen < 0) begin seen = t; g = gpio_in; r = edge_rise; end
        end
        n_checks++; if (seen != 13)       begin n_fail++; $display("FAIL rstmid_latency got %0d want 13", seen); end
        n_checks++; if (r !== 24'h0000F4) begin n_fail++; $display("FAIL rstmid_rise got %h want 0000f4", r); end
        n_checks++; if (g !== 24'h0000F4) begin n_fail++; $display("FAIL rstmid_gpio2 got %h want 0000f4", g); end
    endtask

    task automatic test_limit_change();
        settle('0);
        cfg_en = 1'b1; cfg_limit = 16'd100;
        pad_in[3] = 1'b1;
        repeat (SS + 50) tick();
        n_checks++; if (gpio_in[3] !== 1'b0) begin n_fail++; $display("FAIL limchg_hold got %b want 0", gpio_in[3]); end
        cfg_limit = 16'd2;
        tick();
        n_checks++; if (gpio_in[3] !== 1'b1)   begin n_fail++; $display("FAIL limchg_gpio got %b want 1", gpio_in[3]); end
        n_checks++; if (edge_rise[3] !== 1'b1) begin n_fail++; $display("FAIL limchg_rise got %b want 1", edge_rise[3]); end
    endtask

    task automatic test_disable_mid();
        settle('0);
        cfg_en = 1'b1; cfg_limit = 16'd10;
        pad_in[6] = 1'b1;
        repeat (SS + 4) tick();
        n_checks++; if (gpio_in[6] !== 1'b0) begin n_fail++; $display("FAIL dismid_hold got %b want 0", gpio_in[6]); end
        cfg_en = 1'b0;
        tick();
        n_checks++; if (gpio_in[6] !== 1'b1)   begin n_fail++; $display("FAIL dismid_gpio got %b want 1", gpio_in[6]); end
        n_checks++; if (edge_rise[6] !== 1'b1) begin n_fail++; $display("FAIL dismid_rise got %b want 1", edge_rise[6]); end
        cfg_en = 1'b1;
        tick();
        n_checks++; if (edge_rise !== '0 || edge_fall !== '0) begin
            n_fail++; $display("FAIL reenable_spurious got rise %h fall %h want 0", edge_rise, edge_fall);
        end
    endtask

    task automatic test_random();
        cfg_en = 1'b1; cfg_limit = 16'd3;
        for (int t = 0; t < 1500; t++) begin
            pad_in = pad_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
            if ($urandom_range(0, 31) == 0) cfg_en = ~cfg_en;
            if ($urandom_range(0, 15) == 0) cfg_limit = CNTW'($urandom_range(0, 6));
            glitch_clr = ($urandom_range(0, 49) == 0);
            tick();
            n_checks++; if (gpio_in !== m_gpio)   begin n_fail++; $display("FAIL rnd_gpio t=%0d got %h want %h", t, gpio_in, m_gpio); end
            n_checks++; if (edge_rise !== m_rise) begin n_fail++; $display("FAIL rnd_rise t=%0d got %h want %h", t, edge_rise, m_rise); end
            n_checks++; if (edge_fall !== m_fall) begin n_fail++; $display("FAIL rnd_fall t=%0d got %h want %h", t, edge_fall, m_fall); end
            n_checks++; if ((edge_rise & edge_fall) !== '0) begin
                n_fail++; $display("FAIL rnd_both t=%0d got %h want 0", t, edge_rise & edge_fall);
            end
`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
            n_checks++; if (glitch_cnt !== m_glitch) begin n_fail++; $display("FAIL rnd_glitch t=%0d got %h want %h", t, glitch_cnt, m_glitch); end
`endif
        end
        glitch_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_debounce();
        test_glitch();
        test_multi();
        test_reset_mid();
        test_limit_change();
        test_disable_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
